mem_addr_seq: RTL
=================

Name: mem_addr_seq

Overview:
- Parametrised successor to the CPU's memory-address select mux.
- Selects one of N_SRC address sources (regA, regB, PC, ALUOut, …) into a registered memory address.
- Adds a start/busy/done sequencer for multi-beat accesses with stride, memory-latency wait states and alignment checking.
- Sits between the control unit / datapath registers and the Memoria address port.

Parameters:
- ADDR_W, 32, address width.
- N_SRC, 8, number of address sources.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= N_SRC.
- MEM_LAT, 1, memory read latency in cycles per beat (>= 1).
- MAX_BEATS, 4, maximum beats per sequence (>= 1).

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-low reset.
- src_addr, input, N_SRC*ADDR_W, flattened sources; source k occupies bits [k*ADDR_W +: ADDR_W].
- MemAddrCtrl, input, SEL_W, source select.
- start, input, 1, begin a sequence (sampled in IDLE only).
- beats, input, 3, requested beat count.
- size, input, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr, output, ADDR_W, registered memory address.
- beat_valid, output, 1, memory data for the current mem_addr is valid this cycle.
- busy, output, 1, sequence in progress.
- done, output, 1, one-cycle pulse at sequence end.
- align_err, output, 1, one-cycle pulse with done when the base address is misaligned.

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE. mem_addr, beat_valid, busy, done, align_err = 0. Internal beat and wait counters = 0. Reset mid-sequence aborts immediately; no done pulse.
- Select: MemAddrCtrl >= N_SRC selects source 0.
- IDLE, start==0: mem_addr <= selected source each cycle (1-cycle latency, plain registered mux). busy=0.
- IDLE, start==1:
  - base <= selected source. stride = 1<<size (1, 2, 4).
  - nbeats = beats clamped to [1, MAX_BEATS]; beats==0 is treated as 1.
  - Misaligned when size==01 and base[0]!=0, or size>=10 and base[1:0]!=0. Next state ERR.
  - Otherwise next state ACCESS, mem_addr <= base, beat=0, wait=0.
- ERR (1 cycle): done=1, align_err=1, busy=0, mem_addr holds base, no beat_valid. Then IDLE.
- ACCESS:
  - busy=1. wait increments each cycle.
  - When wait==MEM_LAT-1: beat_valid=1 for that cycle, wait<=0.
  - If beat==nbeats-1: next state DONE.
  - Else beat<=beat+1 and mem_addr <= base + (beat+1)*stride.
  - Each beat therefore lasts exactly MEM_LAT cycles; total ACCESS cycles = nbeats*MEM_LAT.
- DONE (1 cycle): done=1, busy=0, mem_addr holds last beat address. Then IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC + 4 wraps to 0x00000000, with no error.
- start asserted outside IDLE is ignored.
- MemAddrCtrl and src_addr changes during a sequence have no effect; the base address is latched.
- start in the same cycle as DONE/ERR is ignored; it is sampled the next IDLE cycle.

Optional Feature:
- Macro: MEM_ADDR_SEQ_WRAPBURST_EN.
- Defined: beat addresses wrap within the naturally aligned block of size nbeats*stride, with nbeats rounded up to a power of two; addr = (base & ~(blk-1)) | ((base + beat*stride) & (blk-1)). Critical-word-first.
- Undefined: linear increment as in Behaviour. No other difference.

Test Plan:
- Mux mode: reset=1, start=0, src0=5, src1=9; MemAddrCtrl=0 then 1 → mem_addr 5 one cycle later, then 9. MemAddrCtrl=7 with N_SRC=4 → mem_addr=src0.
- Word burst: base=0x100, size=10, beats=3, MEM_LAT=1, start 1 cycle → mem_addr 0x100, 0x104, 0x108 with beat_valid each cycle, busy for 3 cycles, then done=1 and align_err=0.
- Latency/clamp: MEM_LAT=2, beats=0 → one beat; beat_valid only in the 2nd ACCESS cycle, then done. beats=7 with MAX_BEATS=4 → exactly 4 beats.
- Alignment: size=10, base=0x102 → next cycle done=1, align_err=1, beat_valid never asserted. size=01, base=0x102 → normal sequence.
- Wrap/abort: base=0xFFFFFFFC, size=10, beats=2 → mem_addr 0xFFFFFFFC then 0x00000000. Separately, reset=0 mid-burst → all outputs 0 next cycle and no done.
- WRAPBURST_EN defined: base=0x108, size=10, beats=4 → 0x108, 0x10C, 0x100, 0x104.

Source files
------------

// File: rtl/mem_addr_seq.sv
// Registered memory-address select with a start/busy/done multi-beat sequencer.
// Define MEM_ADDR_SEQ_WRAPBURST_EN for critical-word-first wrapping bursts; default is linear.
module mem_addr_seq #(
    parameter int ADDR_W    = 32,
    parameter int N_SRC     = 8,
    parameter int SEL_W     = 3,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BEATS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC*ADDR_W-1:0]   src_addr,
    input  logic [SEL_W-1:0]          MemAddrCtrl,
    input  logic                      start,
    input  logic [2:0]                beats,
    input  logic [1:0]                size,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      beat_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      align_err
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int WAIT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          size_q, size_d;
    logic [BEAT_W-1:0]   nbeats_q, nbeats_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                beat_valid_q, beat_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                align_err_q, align_err_d;
    logic [ADDR_W-1:0]   sel_addr_s;

    function automatic logic [1:0] stride_shift(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return (a[1:0] != 2'b00);
        endcase
    endfunction

    function automatic logic [BEAT_W-1:0] clamp_beats(input logic [2:0] req);
        if (req == 3'd0) begin
            return BEAT_W'(1);
        end else if (32'(req) > MAX_BEATS) begin
            return BEAT_W'(MAX_BEATS);
        end else begin
            return BEAT_W'(req);
        end
    endfunction

`ifdef MEM_ADDR_SEQ_WRAPBURST_EN
    // Block is nbeats rounded up to a power of two, times the stride, naturally aligned.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [1:0]        sz,
                                                     input logic [BEAT_W-1:0] idx,
                                                     input logic [BEAT_W-1:0] nb);
        logic [ADDR_W-1:0] off;
        logic [ADDR_W-1:0] mask;
        int unsigned       lg;
        off = ADDR_W'(idx) << stride_shift(sz);
        lg  = 0;
        for (int i = 0; i <= BEAT_W; i++) begin
            if ((32'd1 << lg) < 32'(nb)) begin
                lg = lg + 1;
            end else begin
                lg = lg;
            end
        end
        mask = (ADDR_W'(1) << (lg + 32'(stride_shift(sz)))) - ADDR_W'(1);
        return (base & ~mask) | ((base + off) & mask);
    endfunction
`else
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [1:0]        sz,
                                                     input logic [BEAT_W-1:0] idx);
        return base + (ADDR_W'(idx) << stride_shift(sz));
    endfunction
`endif

    // Source select; out-of-range selects fall back to source 0.
    always_comb begin
        sel_addr_s = src_addr[0 +: ADDR_W];
        for (int unsigned k = 1; k < N_SRC; k++) begin
            if (32'(MemAddrCtrl) == k) begin
                sel_addr_s = src_addr[k*ADDR_W +: ADDR_W];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Sequencer next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        size_d       = size_q;
        nbeats_d     = nbeats_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        mem_addr_d   = mem_addr_q;
        beat_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        align_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_addr_d = sel_addr_s;
                if (start) begin
                    base_d   = sel_addr_s;
                    size_d   = size;
                    nbeats_d = clamp_beats(beats);
                    beat_d   = '0;
                    wait_d   = '0;
                    if (misaligned(sel_addr_s, size)) begin
                        state_d     = ST_ERR;
                        done_d      = 1'b1;
                        align_err_d = 1'b1;
                    end else begin
                        state_d      = ST_ACCESS;
                        busy_d       = 1'b1;
                        beat_valid_d = (MEM_LAT == 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wait_q == WAIT_W'(MEM_LAT - 1)) begin
                    wait_d = '0;
                    if (beat_q == nbeats_q - BEAT_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d       = beat_q + BEAT_W'(1);
                        busy_d       = 1'b1;
                        beat_valid_d = (MEM_LAT == 1);
`ifdef MEM_ADDR_SEQ_WRAPBURST_EN
                        mem_addr_d   = beat_addr(base_q, size_q, beat_q + BEAT_W'(1), nbeats_q);
`else
                        mem_addr_d   = beat_addr(base_q, size_q, beat_q + BEAT_W'(1));
`endif
                    end
                end else begin
                    wait_d       = wait_q + WAIT_W'(1);
                    busy_d       = 1'b1;
                    beat_valid_d = ((wait_q + WAIT_W'(1)) == WAIT_W'(MEM_LAT - 1));
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            size_q       <= 2'b00;
            nbeats_q     <= '0;
            beat_q       <= '0;
            wait_q       <= '0;
            mem_addr_q   <= '0;
            beat_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            size_q       <= size_d;
            nbeats_q     <= nbeats_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            mem_addr_q   <= mem_addr_d;
            beat_valid_q <= beat_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            align_err_q  <= align_err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign beat_valid = beat_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign align_err  = align_err_q;

endmodule
